branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, branch target address width.
REQ-002 Parameter IMM_W, default 6, branch immediate width.
REQ-003 Parameter SHIFT, default 3, left shift applied to immediate.
REQ-004 Parameter REL, default 0, 0 = absolute target, 1 = pc-relative target.
REQ-005 Parameter CNT_W, default 8, loop counter width; parameter STAT_W, default 16, statistics counter width.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-008 equal, less  input  1 each  comparison results for the current instruction.
REQ-009 w_flag  input  1  load flag_in into flag register at next edge.
REQ-010 flag_in  input  3  new branch-condition mode.
REQ-011 w_count  input  1  load count_in into loop counter at next edge.
REQ-012 count_in  input  CNT_W  loop counter load value.
REQ-013 branch_instr  input  1  current instruction is a branch.
REQ-014 immediate  input  IMM_W  branch immediate.
REQ-015 pc  input  ADDR_W  current instruction address (used only when REL=1).
REQ-016 stat_clr  input  1  clear statistics counters at next edge.
REQ-017 address  output  ADDR_W  branch target.
REQ-018 branch  output  1  take branch this cycle.
REQ-019 flag_q  output  3; loop_count  output  CNT_W; branch_count, taken_count  output  STAT_W each  current register values.

Function
REQ-020 Mode decode on flag_q: 000 NE (!equal), 001 EQ (equal), 010 LT (less), 011 LE (less|equal), 100 ALWAYS (1), 101 LOOP (loop_count != 0), 110 GE (!less), 111 GT (!less & !equal).
REQ-021 branch SHALL be combinational: branch_instr & reset & cond(flag_q); 0 whenever branch_instr=0 or reset=0.
REQ-022 REL=0: address = {immediate, SHIFT zeros}, zero-extended or truncated to ADDR_W.
REQ-023 REL=1: address = pc + (sign-extended immediate << SHIFT), modulo 2^ADDR_W (wraps silently).
REQ-024 address SHALL be driven every cycle independent of branch_instr.
REQ-025 Branch decision in a cycle with w_flag=1 SHALL use the pre-edge flag_q; new mode applies from the following cycle.
REQ-026 LOOP mode: when branch_instr=1 and loop_count != 0, loop_count decrements by 1 at the edge; at loop_count=0 branch=0 and loop_count stays 0 (no underflow).
REQ-027 w_count=1 SHALL override a same-cycle LOOP decrement; the loaded value is count_in exactly.
REQ-028 branch_count increments on each edge with branch_instr=1; taken_count increments on each edge with branch=1.
REQ-029 Both statistics counters SHALL saturate at 2^STAT_W-1.
REQ-030 stat_clr=1 SHALL clear both statistics counters, taking priority over a same-cycle increment.
REQ-031 flag_q, loop_count hold value when not written or decremented.

Reset
REQ-032 On rising clk with reset=0: flag_q=000, loop_count=0, branch_count=0, taken_count=0; all loads, decrements and increments suppressed that edge.
REQ-033 Reset asserted mid-loop SHALL abort the loop; first cycle after release runs in NE mode with loop_count=0.
REQ-034 After reset with no writes: branch_instr=1, equal=0 -> branch=1 (NE mode).

Verification
REQ-035 Modes: for each flag_q 000-111, drive all four (equal, less) combos with branch_instr=1 -> branch matches REQ-020 table; branch_instr=0 -> branch=0.
REQ-036 Loop: w_flag=1 flag_in=101, w_count=1 count_in=3, then 5 branch cycles -> branch 1,1,1,0,0; loop_count 3->2->1->0->0.
REQ-037 Collision: loop_count=2, branch_instr=1 with w_count=1 count_in=7 -> branch=1, loop_count=7 next cycle; w_flag with branch_instr uses old mode.
REQ-038 Address: REL=0, immediate=6'h3F -> address=10'h1F8; REL=1, pc=10'h004, immediate=6'h3F (-1) -> address=10'h3FC (wrap).
REQ-039 Stats: STAT_W=4, 20 taken branches -> taken_count=15 saturated; stat_clr with branch_instr=1 -> both counters 0.
REQ-040 Reset: reset=0 mid-loop (loop_count=5, flag_q=101) -> next cycle all registers 0, branch=0 during reset.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch decision unit: 8-way condition decode, loop counter, target address
// generation (absolute or pc-relative) and saturating branch statistics.
module branch_ctrl #(
  parameter int ADDR_W = 10,
  parameter int IMM_W  = 6,
  parameter int SHIFT  = 3,
  parameter int REL    = 0,
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              equal,
  input  logic              less,
  input  logic              w_flag,
  input  logic [2:0]        flag_in,
  input  logic              w_count,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              branch_instr,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stat_clr,
  output logic [ADDR_W-1:0] address,
  output logic              branch,
  output logic [2:0]        flag_q,
  output logic [CNT_W-1:0]  loop_count,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] taken_count
);

  typedef enum logic [2:0] {
    M_NE = 3'b000, M_EQ = 3'b001, M_LT = 3'b010, M_LE     = 3'b011,
    M_AL = 3'b100, M_LP = 3'b101, M_GE = 3'b110, M_GT     = 3'b111
  } mode_e;

  localparam int EW = ADDR_W + IMM_W + SHIFT;

  logic cond;
  logic loop_nz;

  assign loop_nz = (loop_count != '0);

  always_comb begin
    cond = 1'b0;
    case (mode_e'(flag_q))
      M_NE: cond = !equal;
      M_EQ: cond = equal;
      M_LT: cond = less;
      M_LE: cond = less | equal;
      M_AL: cond = 1'b1;
      M_LP: cond = loop_nz;
      M_GE: cond = !less;
      M_GT: cond = !less & !equal;
      default: cond = 1'b0;
    endcase
  end

  assign branch = branch_instr & reset & cond;

  // Work in a width wide enough for the shifted immediate and pc, then truncate.
  generate
    if (REL == 0) begin : g_abs
      logic unused_pc;
      assign unused_pc = ^pc;
      assign address = ADDR_W'({{(EW-IMM_W){1'b0}}, immediate} << SHIFT);
    end else begin : g_rel
      assign address = ADDR_W'({{(EW-ADDR_W){1'b0}}, pc} +
                               ({{(EW-IMM_W){immediate[IMM_W-1]}}, immediate} << SHIFT));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_q       <= 3'b000;
      loop_count   <= '0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (w_flag)
        flag_q <= flag_in;
      // A load wins over the decrement of the branch taken in the same cycle.
      if (w_count)
        loop_count <= count_in;
      else if (branch_instr && flag_q == M_LP && loop_nz)
        loop_count <= loop_count - CNT_W'(1);
      if (stat_clr) begin
        branch_count <= '0;
        taken_count  <= '0;
      end else begin
        if (branch_instr && branch_count != '1)
          branch_count <= branch_count + STAT_W'(1);
        if (branch && taken_count != '1)
          taken_count <= taken_count + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Vector/scoreboard bench for branch_ctrl: default instance plus a REL=1,
// STAT_W=4 instance sharing the same stimulus.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       equal = 1'b0, less = 1'b0, w_flag = 1'b0, w_count = 1'b0;
  logic       branch_instr = 1'b0, stat_clr = 1'b0;
  logic [2:0] flag_in = '0;
  logic [7:0] count_in = '0;
  logic [5:0] immediate = '0;
  logic [9:0] pc = '0;

  logic [9:0]  address, address_r;
  logic        branch, branch_r;
  logic [2:0]  flag_q, flag_q_r;
  logic [7:0]  loop_count, loop_count_r;
  logic [15:0] branch_count, taken_count;
  logic [3:0]  branch_count_r, taken_count_r;

  int n_cmp = 0;
  int n_fail = 0;

  branch_ctrl dut (
    .clk(clk), .reset(reset), .equal(equal), .less(less), .w_flag(w_flag),
    .flag_in(flag_in), .w_count(w_count), .count_in(count_in),
    .branch_instr(branch_instr), .immediate(immediate), .pc(pc),
    .stat_clr(stat_clr), .address(address), .branch(branch), .flag_q(flag_q),
    .loop_count(loop_count), .branch_count(branch_count), .taken_count(taken_count)
  );

  branch_ctrl #(.REL(1), .STAT_W(4)) dut_r (
    .clk(clk), .reset(reset), .equal(equal), .less(less), .w_flag(w_flag),
    .flag_in(flag_in), .w_count(w_count), .count_in(count_in),
    .branch_instr(branch_instr), .immediate(immediate), .pc(pc),
    .stat_clr(stat_clr), .address(address_r), .branch(branch_r), .flag_q(flag_q_r),
    .loop_count(loop_count_r), .branch_count(branch_count_r), .taken_count(taken_count_r)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      nm;
    logic       rst, bi, eq, lt, wf, wc, sc;
    logic [2:0] fi;
    logic [7:0] ci;
    logic       e_br;
    logic [2:0] e_fl;
    logic [7:0] e_lc;
  } vec_t;

  vec_t sbq[$];
  int   cnt_b, cnt_t, cnt_b4, cnt_t4;

  function automatic vec_t mk(string nm, bit rst, bit bi, bit eq, bit lt,
                              bit wf, logic [2:0] fi, bit wc, logic [7:0] ci,
                              bit e_br, logic [2:0] e_fl, logic [7:0] e_lc);
    vec_t v;
    v.nm = nm; v.rst = rst; v.bi = bi; v.eq = eq; v.lt = lt; v.wf = wf;
    v.fi = fi; v.wc = wc; v.ci = ci; v.sc = 1'b0;
    v.e_br = e_br; v.e_fl = e_fl; v.e_lc = e_lc;
    return v;
  endfunction

  // Condition table written straight from the mode list.
  function automatic bit cond_ref(logic [2:0] m, bit eq, bit lt, bit lp_nz);
    case (m)
      3'd0: return !eq;
      3'd1: return eq;
      3'd2: return lt;
      3'd3: return lt || eq;
      3'd4: return 1'b1;
      3'd5: return lp_nz;
      3'd6: return !lt;
      default: return !lt && !eq;
    endcase
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_one();
    vec_t e;
    if (sbq.size() == 0) begin
      cmp("scoreboard_empty", 1, 0);
      return;
    end
    e = sbq.pop_front();
    cmp({e.nm, ".branch"}, 32'(branch), 32'(e.e_br));
    cmp({e.nm, ".flag_q"}, 32'(flag_q), 32'(e.e_fl));
    cmp({e.nm, ".loop_count"}, 32'(loop_count), 32'(e.e_lc));
  endtask

  // Drive one cycle, queue its expectation, compare mid-cycle, then clock.
  task automatic drive(vec_t v);
    reset = v.rst; branch_instr = v.bi; equal = v.eq; less = v.lt;
    w_flag = v.wf; flag_in = v.fi; w_count = v.wc; count_in = v.ci;
    stat_clr = v.sc;
    sbq.push_back(v);
    @(negedge clk);
    check_one();
    if (!v.rst || v.sc) begin
      cnt_b = 0; cnt_t = 0; cnt_b4 = 0; cnt_t4 = 0;
    end else begin
      if (v.bi) begin cnt_b++; if (cnt_b4 < 15) cnt_b4++; end
      if (v.e_br) begin cnt_t++; if (cnt_t4 < 15) cnt_t4++; end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //            name        rst bi eq lt wf fi wc ci   br fl lc
    tbl.push_back(mk("in_rst",  0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("ne_post", 1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(mk("ne_eq",   1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0));
    tbl.push_back(mk("lp_set",  1, 0, 0, 0, 1, 5, 1, 3,   0, 0, 0));
    tbl.push_back(mk("lp_1",    1, 1, 0, 0, 0, 0, 0, 0,   1, 5, 3));
    tbl.push_back(mk("lp_2",    1, 1, 0, 0, 0, 0, 0, 0,   1, 5, 2));
    tbl.push_back(mk("lp_3",    1, 1, 0, 0, 0, 0, 0, 0,   1, 5, 1));
    tbl.push_back(mk("lp_4",    1, 1, 0, 0, 0, 0, 0, 0,   0, 5, 0));
    tbl.push_back(mk("lp_5",    1, 1, 0, 0, 0, 0, 0, 0,   0, 5, 0));
    tbl.push_back(mk("lp_hold", 1, 0, 0, 0, 0, 0, 0, 0,   0, 5, 0));
    tbl.push_back(mk("col_ld",  1, 0, 0, 0, 0, 0, 1, 2,   0, 5, 0));
    tbl.push_back(mk("col_hit", 1, 1, 0, 0, 0, 0, 1, 7,   1, 5, 2));
    tbl.push_back(mk("col_chk", 1, 0, 0, 0, 0, 0, 0, 0,   0, 5, 7));
    tbl.push_back(mk("wf_old",  1, 1, 0, 0, 1, 1, 0, 0,   1, 5, 7));
    tbl.push_back(mk("wf_new",  1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 6));
    tbl.push_back(mk("rl_set",  1, 0, 0, 0, 1, 5, 1, 5,   0, 1, 6));
    tbl.push_back(mk("rl_rst",  0, 1, 0, 0, 0, 0, 0, 0,   0, 5, 5));
    tbl.push_back(mk("rl_post", 1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(mk("rl_eq",   1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0));
    foreach (tbl[i]) drive(tbl[i]);

    // Counters after the last reset: rl_post and rl_eq are branches, one taken.
    @(negedge clk);
    cmp("stat.branch_count", 32'(branch_count), 32'(cnt_b));
    cmp("stat.taken_count", 32'(taken_count), 32'(cnt_t));
    cmp("stat.branch_count_r", 32'(branch_count_r), 32'(cnt_b4));
    @(posedge clk); #1;

    // Mode sweep, loop counter held at 0.
    for (int m = 0; m < 8; m++) begin
      drive(mk($sformatf("sw%0d_w", m), 1, 0, 0, 0, 1, 3'(m), 1, 0,
               0, (m == 0) ? 3'd0 : 3'(m - 1), 0));
      for (int c = 0; c < 4; c++) begin
        drive(mk($sformatf("sw%0d_c%0d", m, c), 1, 1, c[0], c[1], 0, 0, 0, 0,
                 cond_ref(3'(m), c[0], c[1], 1'b0), 3'(m), 0));
        drive(mk($sformatf("sw%0d_c%0d_nb", m, c), 1, 0, c[0], c[1], 0, 0, 0, 0,
                 0, 3'(m), 0));
      end
    end

    // Address generation, both target styles.
    begin
      typedef struct { logic [5:0] imm; logic [9:0] pc; logic [9:0] e_abs, e_rel; } at_t;
      at_t at[4];
      at[0] = '{6'h3F, 10'h004, 10'h1F8, 10'h3FC};
      at[1] = '{6'h01, 10'h3FF, 10'h008, 10'h007};
      at[2] = '{6'h20, 10'h200, 10'h100, 10'h100};
      at[3] = '{6'h1F, 10'h010, 10'h0F8, 10'h108};
      for (int i = 0; i < 4; i++) begin
        immediate = at[i].imm; pc = at[i].pc; branch_instr = (i % 2 == 0);
        @(negedge clk);
        cmp($sformatf("addr_abs%0d", i), 32'(address), 32'(at[i].e_abs));
        cmp($sformatf("addr_rel%0d", i), 32'(address_r), 32'(at[i].e_rel));
        @(posedge clk); #1;
      end
      branch_instr = 1'b0;
    end

    // Saturation: ALWAYS mode, 20 taken branches.
    drive(mk("sat_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd7, 0));
    drive(mk("sat_w", 1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++)
      drive(mk($sformatf("sat_%0d", i), 1, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0));
    @(negedge clk);
    cmp("sat.taken_count_r", 32'(taken_count_r), 32'(cnt_t4));
    cmp("sat.branch_count_r", 32'(branch_count_r), 32'(cnt_b4));
    cmp("sat.taken_lit", 32'(taken_count_r), 32'd15);
    cmp("sat.taken_count", 32'(taken_count), 32'(cnt_t));
    cmp("sat.branch_count", 32'(branch_count), 32'd20);
    @(posedge clk); #1;

    // Clear wins over a same-cycle increment.
    v = mk("clr", 1, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    v.sc = 1'b1;
    drive(v);
    drive(mk("clr_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0));
    @(negedge clk);
    cmp("clr.branch_count", 32'(branch_count), 32'd0);
    cmp("clr.taken_count", 32'(taken_count), 32'd0);
    cmp("clr.branch_count_r", 32'(branch_count_r), 32'd0);
    cmp("clr.taken_count_r", 32'(taken_count_r), 32'd0);

    if (sbq.size() != 0) cmp("scoreboard_leftover", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
